// File: rtl/tdm_demux.sv
// tdm_demux: two-channel serial TDM demultiplexer; words arrive LSB first.
// Ports: clk, rst_n, in, Sel, in_valid, flush -> Q0, Q1, Q0_valid, Q1_valid, par_err.
// Build option TDM_DEMUX_PARITY_EN: each word carries a trailing even-parity bit.
module tdm_demux #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in,
  input  logic         Sel,
  input  logic         in_valid,
  input  logic         flush,
  output logic [W-1:0] Q0,
  output logic [W-1:0] Q1,
  output logic         Q0_valid,
  output logic         Q1_valid,
  output logic         par_err
);

  localparam int CW = $clog2(W + 1);
`ifdef TDM_DEMUX_PARITY_EN
  localparam int SW   = W;
  localparam int LAST = W;
`else
  // The final data bit bypasses the register straight into Q,
  // so only W-1 bits need storing.
  localparam int SW   = W - 1;
  localparam int LAST = W - 1;
`endif
  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  logic [SW-1:0] sr  [2];
  logic [CW-1:0] cnt [2];
  logic [SW-1:0] sr_shift;
  logic [W-1:0]  word;
  logic          last;
  logic          good;

`ifdef TDM_DEMUX_PARITY_EN
  logic          par [2];
  logic          perr;
`endif

  always_comb begin
    sr_shift = {in, sr[Sel][SW-1:1]};
    last     = (cnt[Sel] == LAST_C);
`ifdef TDM_DEMUX_PARITY_EN
    word     = sr[Sel];
    good     = ~(par[Sel] ^ in);
`else
    word     = {in, sr[Sel]};
    good     = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        sr[c]  <= '0;
        cnt[c] <= '0;
`ifdef TDM_DEMUX_PARITY_EN
        par[c] <= 1'b0;
`endif
      end
      Q0       <= '0;
      Q1       <= '0;
      Q0_valid <= 1'b0;
      Q1_valid <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr     <= 1'b0;
`endif
    end else begin
      Q0_valid <= 1'b0;
      Q1_valid <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr     <= 1'b0;
`endif
      if (flush) begin
        for (int c = 0; c < 2; c++) begin
          sr[c]  <= '0;
          cnt[c] <= '0;
`ifdef TDM_DEMUX_PARITY_EN
          par[c] <= 1'b0;
`endif
        end
      end else if (in_valid) begin
        if (last) begin
          cnt[Sel] <= '0;
          sr[Sel]  <= '0;
`ifdef TDM_DEMUX_PARITY_EN
          par[Sel] <= 1'b0;
          if (!good) perr <= 1'b1;
`endif
          if (good) begin
            if (Sel) begin
              Q1       <= word;
              Q1_valid <= 1'b1;
            end else begin
              Q0       <= word;
              Q0_valid <= 1'b1;
            end
          end
        end else begin
          cnt[Sel] <= cnt[Sel] + 1'b1;
          sr[Sel]  <= sr_shift;
`ifdef TDM_DEMUX_PARITY_EN
          par[Sel] <= par[Sel] ^ in;
`endif
        end
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  assign par_err = perr;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed self-checking bench for tdm_demux (W=8).
// Word table applied back to back, plus flush, reset, gap and parity sequences.
module tb_tdm_demux;

  localparam int W = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in;
  logic         Sel;
  logic         in_valid;
  logic         flush;
  logic [W-1:0] Q0;
  logic [W-1:0] Q1;
  logic         Q0_valid;
  logic         Q1_valid;
  logic         par_err;

  int errors = 0;
  int checks = 0;

  tdm_demux #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .Sel      (Sel),
    .in_valid (in_valid),
    .flush    (flush),
    .Q0       (Q0),
    .Q1       (Q1),
    .Q0_valid (Q0_valid),
    .Q1_valid (Q1_valid),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           ch;
    logic [W-1:0] data;
    logic [W-1:0] exp_q0;
    logic [W-1:0] exp_q1;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit bit_of(input logic [W-1:0] d, input int i,
                                input bit bad);
    if (i < W) return d[i];
    return (^d) ^ bad;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input bit ch, input bit b);
    Sel      = ch;
    in       = b;
    in_valid = 1'b1;
  endtask

  task automatic send_word(input bit ch, input logic [W-1:0] d,
                           input bit bad, input bit gaps);
    for (int i = 0; i < NB; i++) begin
      if (gaps && i > 0) idle($urandom_range(1, 3));
      drive(ch, bit_of(d, i, bad));
      tick();
      if (i == 0)
        chk("pulse_drop", {30'd0, Q0_valid, Q1_valid}, 32'd0);
    end
  endtask

  task automatic chk_done(input bit ch, input logic [W-1:0] q0,
                          input logic [W-1:0] q1, input string nm);
    chk({nm, "_q0"}, 32'(Q0), 32'(q0));
    chk({nm, "_q1"}, 32'(Q1), 32'(q1));
    chk({nm, "_vld"}, {30'd0, Q0_valid, Q1_valid},
        ch ? 32'd1 : 32'd2);
    chk({nm, "_perr"}, 32'(par_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit overlap;

    tbl[0] = '{1'b0, 8'hA5, 8'hA5, 8'h00};
    tbl[1] = '{1'b1, 8'h5A, 8'hA5, 8'h5A};
    tbl[2] = '{1'b0, 8'hFF, 8'hFF, 8'h5A};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 8'h5A};
    tbl[4] = '{1'b1, 8'h81, 8'h00, 8'h81};

    rst_n = 1'b0; in = 1'b0; Sel = 1'b0;
    in_valid = 1'b0; flush = 1'b0;
    #3;
    chk("rst_q0", 32'(Q0), 32'd0);
    chk("rst_q1", 32'(Q1), 32'd0);
    chk("rst_flags", {29'd0, Q0_valid, Q1_valid, par_err}, 32'd0);
    #9 rst_n = 1'b1;
    idle(1);

    for (int k = 0; k < 5; k++) begin
      send_word(tbl[k].ch, tbl[k].data, 1'b0, 1'b0);
      chk_done(tbl[k].ch, tbl[k].exp_q0, tbl[k].exp_q1,
               $sformatf("tbl%0d", k));
    end
    idle(1);
    chk("pulse_end", {30'd0, Q0_valid, Q1_valid}, 32'd0);
    idle(2);
    chk("hold_q0", 32'(Q0), 32'h00);
    chk("hold_q1", 32'(Q1), 32'h81);

    a = 8'h3C;
    b = 8'hC3;
    overlap = 1'b0;
    for (int i = 0; i < NB; i++) begin
      drive(1'b0, bit_of(a, i, 1'b0));
      tick();
      overlap |= Q0_valid & Q1_valid;
      if (i == NB - 1) chk_done(1'b0, 8'h3C, 8'h81, "ilv_c0");
      drive(1'b1, bit_of(b, i, 1'b0));
      tick();
      overlap |= Q0_valid & Q1_valid;
      if (i == NB - 1) chk_done(1'b1, 8'h3C, 8'hC3, "ilv_c1");
    end
    chk("ilv_overlap", 32'(overlap), 32'd0);

    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b1);
    flush = 1'b1;
    tick();
    chk("flush_keep_q0", 32'(Q0), 32'h3C);
    chk("flush_no_vld", {30'd0, Q0_valid, Q1_valid}, 32'd0);
    send_word(1'b0, 8'h0F, 1'b0, 1'b0);
    chk_done(1'b0, 8'h0F, 8'hC3, "flush_word");

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1);
      tick();
    end
    #1 rst_n = 1'b0;
    #1;
    chk("arst_q0", 32'(Q0), 32'd0);
    chk("arst_q1", 32'(Q1), 32'd0);
    chk("arst_flags", {29'd0, Q0_valid, Q1_valid, par_err}, 32'd0);
    #2 rst_n = 1'b1;
    idle(1);
    send_word(1'b1, 8'h81, 1'b0, 1'b0);
    chk_done(1'b1, 8'h00, 8'h81, "post_rst");

    idle(1);
    send_word(1'b0, 8'hA5, 1'b0, 1'b1);
    chk_done(1'b0, 8'hA5, 8'h81, "gaps");

`ifdef TDM_DEMUX_PARITY_EN
    idle(1);
    send_word(1'b0, 8'h5A, 1'b0, 1'b0);
    chk_done(1'b0, 8'h5A, 8'h81, "par_good");
    send_word(1'b0, 8'h5A, 1'b1, 1'b0);
    chk("par_bad_q0", 32'(Q0), 32'h5A);
    chk("par_bad_flags", {29'd0, Q0_valid, Q1_valid, par_err}, 32'd1);
    idle(1);
    chk("par_err_end", 32'(par_err), 32'd0);
    send_word(1'b0, 8'h3C, 1'b1, 1'b0);
    chk("par_bad2_q0", 32'(Q0), 32'h5A);
    chk("par_bad2_flags", {29'd0, Q0_valid, Q1_valid, par_err}, 32'd1);
`endif

    idle(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter: W, default 8, data bits per channel word.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in  input  1  serial multiplexed data bit.
REQ-005 Port: Sel  input  1  channel tag of current bit (0 = channel 0, 1 = channel 1).
REQ-006 Port: in_valid  input  1  in and Sel sampled only when high.
REQ-007 Port: flush  input  1  synchronous discard of both partial words.
REQ-008 Port: Q0  output  W  last completed channel-0 word.
REQ-009 Port: Q1  output  W  last completed channel-1 word.
REQ-010 Port: Q0_valid  output  1  one-cycle pulse, Q0 updated.
REQ-011 Port: Q1_valid  output  1  one-cycle pulse, Q1 updated.
REQ-012 Port: par_err  output  1  one-cycle pulse, parity failure.

Function
REQ-013 Each channel SHALL own an independent shift register and bit counter; a bit with in_valid=1 goes only to the channel named by Sel.
REQ-014 Bits SHALL be LSB first; bit k of a word is the k-th accepted bit for that channel.
REQ-015 Switching Sel mid-word SHALL preserve the other channel's partial word and count unchanged.
REQ-016 On the edge accepting a channel's final data bit (parity disabled), Q<n> SHALL load the full word and Q<n>_valid SHALL be high for exactly the following cycle (latency 1 clock).
REQ-017 After completing a word, that channel's counter SHALL wrap to 0; back-to-back words on one channel SHALL give back-to-back valid pulses with no gap cycle.
REQ-018 Q0/Q1 SHALL hold their value between completions; in_valid=0 cycles SHALL not change any state.
REQ-019 Word completions on channel 0 and channel 1 are never simultaneous (one bit per cycle); two valids SHALL never assert in the same cycle.
REQ-020 flush=1 SHALL clear both counters and shift registers on that edge; a bit presented with in_valid=1 in the same cycle SHALL be discarded (flush wins); Q0/Q1 SHALL be retained.
REQ-021 Per-channel counter width SHALL be clog2(W+1) bits; no counter overflow is possible.

Reset
REQ-022 rst_n=0 SHALL immediately clear counters, shift registers, Q0, Q1, Q0_valid, Q1_valid and par_err to 0, regardless of clk.
REQ-023 Reset asserted mid-word SHALL discard the partial word; the first accepted bit after release is bit 0 of a new word.
REQ-024 Release of rst_n SHALL take effect at the next rising edge of clk.

Configuration
REQ-025 Macro TDM_DEMUX_PARITY_EN, when defined, SHALL make each channel word W data bits plus one trailing even-parity bit (XOR of all W+1 bits = 0).
REQ-026 With TDM_DEMUX_PARITY_EN defined: on the parity-bit edge, a good word loads Q<n> and pulses Q<n>_valid next cycle; a bad word leaves Q<n> unchanged, pulses par_err next cycle, no valid; counter wraps in both cases.
REQ-027 Without TDM_DEMUX_PARITY_EN: words are W bits, no parity bit consumed, par_err tied to 0.

Verification
REQ-028 W=8, no parity: 8 bits of 0xA5 LSB first with Sel=0 -> Q0=0xA5, Q0_valid one cycle after 8th bit, Q1 stays 0x00.
REQ-029 Interleave: channel-0 0x3C and channel-1 0xC3 alternating bit by bit -> Q0=0x3C then Q1=0xC3 on consecutive cycles, valids never overlap.
REQ-030 4 bits to channel 0, flush with in_valid=1, then 8 bits of 0x0F -> Q0=0x0F, flushed bit and partial bits absent.
REQ-031 rst_n low for 3 ns between clk edges after 5 bits on channel 1 -> all outputs 0 at once; next 8 bits 0x81 -> Q1=0x81.
REQ-032 PARITY_EN: 0x5A with parity 0 -> Q0=0x5A, Q0_valid; then 0x5A with parity 1 -> Q0 stays 0x5A, par_err one cycle, no Q0_valid.
REQ-033 in_valid gaps of 1-3 cycles randomly inserted in REQ-028 stimulus -> identical Q0=0xA5 result.
